// File: rtl/nes_joypad_port.sv
// nes_joypad_port
//   Emulates C_ports NES controller shift registers with per-port A/B
//   autofire. Buttons are synchronised, gated by the autofire phase, then
//   latched while joy_strobe is high and shifted out LSB first on each
//   falling edge of joy_clock.
// Ports:
//   clock          system clock, rising edge
//   R_reset        synchronous active-high reset
//   btn_in         raw buttons, 8 per port {R,L,D,U,start,select,B,A}
//   autofire_en    per-port autofire enable, {B,A} per port
//   joy_strobe     latch request from the NES core
//   joy_clock      shared read clock from the NES core
//   joy_data       serial report bit per port (1 = pressed)
//   latch_pulse    one-cycle pulse after joy_strobe falls
//   autofire_phase current autofire gate level
module nes_joypad_port #(
    parameter int   C_ports       = 2,
    parameter int   C_clk_hz      = 21428571,
    parameter int   C_autofire_hz = 10,
    parameter int   C_sync_stages = 2,
    parameter logic C_fill        = 1'b1
) (
    input  logic                   clock,
    input  logic                   R_reset,
    input  logic [8*C_ports-1:0]   btn_in,
    input  logic [2*C_ports-1:0]   autofire_en,
    input  logic                   joy_strobe,
    input  logic                   joy_clock,
    output logic [C_ports-1:0]     joy_data,
    output logic                   latch_pulse,
    output logic                   autofire_phase
);

    // ---------------------------------------------------------------
    // Input synchronisers
    // ---------------------------------------------------------------
    logic [C_sync_stages-1:0][8*C_ports-1:0] r_btn_sync;
    logic [C_sync_stages-1:0][2*C_ports-1:0] r_af_sync;
    logic [8*C_ports-1:0]                    w_btn_s;
    logic [2*C_ports-1:0]                    w_af_s;

    always_ff @(posedge clock) begin
        if (R_reset) begin
            r_btn_sync <= '0;
            r_af_sync  <= '0;
        end else begin
            r_btn_sync[0] <= btn_in;
            r_af_sync[0]  <= autofire_en;
            for (int i = 1; i < C_sync_stages; i++) begin
                r_btn_sync[i] <= r_btn_sync[i-1];
                r_af_sync[i]  <= r_af_sync[i-1];
            end
        end
    end

    assign w_btn_s = r_btn_sync[C_sync_stages-1];
    assign w_af_s  = r_af_sync[C_sync_stages-1];

    // ---------------------------------------------------------------
    // Autofire divider: phase toggles every HALF cycles
    // ---------------------------------------------------------------
    logic w_phase;

    generate
        if (C_autofire_hz > 0) begin : g_af
            localparam int HALF = C_clk_hz / (2 * C_autofire_hz);
            localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
            logic [CW-1:0] r_cnt;
            logic          r_phase;

            always_ff @(posedge clock) begin
                if (R_reset) begin
                    r_cnt   <= '0;
                    r_phase <= 1'b0;
                end else if (r_cnt == CW'(HALF - 1)) begin
                    r_cnt   <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_cnt   <= r_cnt + 1'b1;
                end
            end

            assign w_phase = r_phase;
        end else begin : g_no_af
            // No divider: the gate is permanently open.
            assign w_phase = 1'b1;
        end
    endgenerate

    assign autofire_phase = w_phase;

    // ---------------------------------------------------------------
    // Effective buttons: A/B masked while autofire is enabled and the
    // phase is low; the other six buttons pass straight through.
    // ---------------------------------------------------------------
    logic [8*C_ports-1:0] w_eff;

    always_comb begin
        w_eff = w_btn_s;
        for (int p = 0; p < C_ports; p++) begin
            w_eff[8*p]   = w_btn_s[8*p]   & (~w_af_s[2*p]   | w_phase);
            w_eff[8*p+1] = w_btn_s[8*p+1] & (~w_af_s[2*p+1] | w_phase);
        end
    end

    // ---------------------------------------------------------------
    // Edge detection on the core's strobe/clock
    // ---------------------------------------------------------------
    logic r_clk_q;
    logic r_strobe_q;
    logic r_latch_pulse;
    logic w_clk_fall;

    assign w_clk_fall = r_clk_q & ~joy_clock;

    always_ff @(posedge clock) begin
        if (R_reset) begin
            r_clk_q       <= 1'b0;
            r_strobe_q    <= 1'b0;
            r_latch_pulse <= 1'b0;
        end else begin
            r_clk_q       <= joy_clock;
            r_strobe_q    <= joy_strobe;
            r_latch_pulse <= r_strobe_q & ~joy_strobe;
        end
    end

    assign latch_pulse = r_latch_pulse;

    // ---------------------------------------------------------------
    // Report shift registers. Strobe wins over a coincident clock fall,
    // so a read clock seen during the latch never consumes a bit.
    // ---------------------------------------------------------------
    logic [C_ports-1:0][7:0] r_sr;

    always_ff @(posedge clock) begin
        if (R_reset) begin
            r_sr <= '0;
        end else begin
            for (int p = 0; p < C_ports; p++) begin
                if (joy_strobe)
                    r_sr[p] <= w_eff[8*p +: 8];
                else if (w_clk_fall)
                    r_sr[p] <= {C_fill, r_sr[p][7:1]};
            end
        end
    end

    always_comb begin
        joy_data = '0;
        for (int p = 0; p < C_ports; p++)
            joy_data[p] = r_sr[p][0];
    end

endmodule

// File: tb/tb_nes_joypad_port.sv
module tb_nes_joypad_port;

    localparam int NP = 2;

    logic            clock = 1'b0;
    logic            R_reset;
    logic [8*NP-1:0] btn_in;
    logic [2*NP-1:0] autofire_en;
    logic            joy_strobe;
    logic            joy_clock;
    logic [NP-1:0]   joy_data;
    logic            latch_pulse;
    logic            autofire_phase;

    int checks = 0;
    int errors = 0;

    // HALF = 1000 / (2*50) = 10 cycles
    nes_joypad_port #(
        .C_ports(NP), .C_clk_hz(1000), .C_autofire_hz(50),
        .C_sync_stages(2), .C_fill(1'b1)
    ) dut (
        .clock(clock), .R_reset(R_reset), .btn_in(btn_in),
        .autofire_en(autofire_en), .joy_strobe(joy_strobe),
        .joy_clock(joy_clock), .joy_data(joy_data),
        .latch_pulse(latch_pulse), .autofire_phase(autofire_phase)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // advance n rising edges, leave time 1 unit after the last edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic jfall();
        joy_clock = 1'b1; tick(1);
        joy_clock = 1'b0; tick(1);
    endtask

    logic [9:0] exp0, exp1;

    initial begin
        R_reset = 1'b1; btn_in = '0; autofire_en = '0;
        joy_strobe = 1'b0; joy_clock = 1'b0;
        tick(3);
        chk("rst_data",  16'(joy_data), 16'h0);
        chk("rst_latch", 16'(latch_pulse), 16'h0);
        chk("rst_phase", 16'(autofire_phase), 16'h0);
        R_reset = 1'b0;

        // ---- basic report: port0 = A, start, right; port1 idle
        btn_in = 16'h0089;
        tick(3);
        joy_strobe = 1'b1; tick(2);
        joy_strobe = 1'b0; tick(1);
        chk("latch_hi", 16'(latch_pulse), 16'h1);
        chk("strobe_data", 16'(joy_data), 16'h1);
        tick(1);
        chk("latch_lo", 16'(latch_pulse), 16'h0);
        exp0 = 10'b11_1000_1001;
        exp1 = 10'b11_0000_0000;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("p0_bit%0d", k), 16'(joy_data[0]), 16'(exp0[k]));
            chk($sformatf("p1_bit%0d", k), 16'(joy_data[1]), 16'(exp1[k]));
            jfall();
        end
        chk("fill_hold", 16'(joy_data), 16'h3);
        chk("latch_quiet", 16'(latch_pulse), 16'h0);

        // ---- latency while strobed: C_sync_stages+1 cycles
        btn_in = 16'h0000; joy_strobe = 1'b1;
        tick(4);
        chk("lat_base", 16'(joy_data[0]), 16'h0);
        btn_in = 16'h0001;
        tick(1); chk("lat_c1", 16'(joy_data[0]), 16'h0);
        tick(1); chk("lat_c2", 16'(joy_data[0]), 16'h0);
        tick(1); chk("lat_c3", 16'(joy_data[0]), 16'h1);

        // ---- strobe beats a coincident clock fall
        btn_in = 16'h0003; tick(3);
        joy_strobe = 1'b0; tick(1);
        chk("pri_pre", 16'(joy_data[0]), 16'h1);
        btn_in = 16'h0002; tick(3);
        chk("release_unstrobed", 16'(joy_data[0]), 16'h1);
        joy_clock = 1'b1; tick(1);
        joy_strobe = 1'b1; joy_clock = 1'b0; tick(1);
        chk("pri_load", 16'(joy_data[0]), 16'h0);
        joy_strobe = 1'b0; tick(1);
        jfall();
        chk("pri_bit1", 16'(joy_data[0]), 16'h1);

        // ---- reset mid-read
        btn_in = 16'h01FF; tick(3);
        joy_strobe = 1'b1; tick(1);
        joy_strobe = 1'b0; tick(1);
        jfall(); jfall(); jfall();
        chk("mid_read", 16'(joy_data), 16'h1);
        R_reset = 1'b1; tick(1);
        chk("mid_rst", 16'(joy_data), 16'h0);
        R_reset = 1'b0; tick(1);
        chk("post_rst_idle", 16'(joy_data), 16'h0);
        tick(2);
        joy_strobe = 1'b1; tick(1);
        joy_strobe = 1'b0; tick(1);
        chk("fresh_report", 16'(joy_data), 16'h3);

        // ---- autofire: A gated on port0, port1 A ungated, B ungated
        R_reset = 1'b1; tick(1);
        R_reset = 1'b0;
        btn_in = 16'h0103; autofire_en = 4'b0001; joy_strobe = 1'b1;
        for (int n = 1; n <= 25; n++) begin
            tick(1);
            // phase after n edges = (n/10)%2; data reflects phase at n-1
            if (n == 9)  chk("ph9",  16'(autofire_phase), 16'h0);
            if (n == 10) chk("ph10", 16'(autofire_phase), 16'h1);
            if (n == 19) chk("ph19", 16'(autofire_phase), 16'h1);
            if (n == 20) chk("ph20", 16'(autofire_phase), 16'h0);
            if (n == 5)  chk("af_a5",  16'(joy_data[0]), 16'h0);
            if (n == 10) chk("af_a10", 16'(joy_data), 16'h2);
            if (n == 11) chk("af_a11", 16'(joy_data), 16'h3);
            if (n == 15) chk("af_a15", 16'(joy_data[0]), 16'h1);
            if (n == 21) chk("af_a21", 16'(joy_data[0]), 16'h0);
            if (n == 25) chk("af_a25", 16'(joy_data), 16'h2);
        end
        joy_strobe = 1'b0; tick(1);
        jfall();
        chk("af_b", 16'(joy_data[0]), 16'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nes_joypad_port.md
# nes_joypad_port

Multi-port NES controller shift-register emulator with per-button autofire. It sits between the board button sources (onboard BTNs and USB HID decoder) and the NES core's `joypad_strobe`/`joypad_clock`/`joypad_data` pins. It generalises the single 2-bit inline joypad logic to C_ports full 8-bit controllers. It adds input synchronisation, autofire gating, a configurable post-report fill value and a latch-event output.

## Interface
Parameters:
- C_ports, 2, number of controller ports (1..4)
- C_clk_hz, 21428571, frequency of `clock` in Hz
- C_autofire_hz, 10, autofire press rate in Hz; 0 disables autofire
- C_sync_stages, 2, synchroniser flops on btn_in (≥1)
- C_fill, 1, bit shifted into the MSB on each read; standard controller reports 1 after 8 reads

Ports:
- clock  in  1  NES system clock; all logic is on the rising edge
- R_reset  in  1  synchronous, active-high reset
- btn_in  in  8*C_ports  raw buttons, active-high. Port p occupies bits [8p+7:8p], in the order 0 A, 1 B, 2 select, 3 start, 4 up, 5 down, 6 left, 7 right
- autofire_en  in  2*C_ports  per-port autofire enable. Bit 2p is A, bit 2p+1 is B. Synchronised together with btn_in
- joy_strobe  in  1  latch request from the NES core (same clock domain)
- joy_clock  in  1  per-port read clock from the NES core (same clock domain); all ports share it
- joy_data  out  C_ports  current serial bit per port, active-high pressed
- latch_pulse  out  1  one-cycle pulse on the falling edge of joy_strobe
- autofire_phase  out  1  current autofire gate level, for debug and LED use

## Operation
- Synchroniser: btn_in and autofire_en each pass through C_sync_stages flops. The output of the last stage is `btn_s`/`af_s`.
- Autofire divider:
  - HALF = C_clk_hz/(2*C_autofire_hz), using integer division.
  - The counter runs 0..HALF-1. On HALF-1 it wraps to 0 and toggles `autofire_phase`.
  - With C_autofire_hz=0 there is no counter, and `autofire_phase` is constant 1.
- Effective buttons:
  - eff[8p+0] = btn_s[8p+0] & (~af_s[2p] | autofire_phase).
  - eff[8p+1] = btn_s[8p+1] & (~af_s[2p+1] | autofire_phase).
  - Bits 2..7 pass through unchanged.
- Shift registers: there is one 8-bit register `sr[p]` per port, and joy_data[p] = sr[p][0].
  - Load: while joy_strobe=1, every cycle sr[p] <= eff[8p+7:8p]. The register is transparent, so A is continuously visible.
  - Shift: if joy_strobe=0 and a joy_clock falling edge is detected (previous=1, current=0), every sr[p] <= {C_fill, sr[p][7:1]}.
  - Priority: strobe beats shift when both occur in the same cycle.
  - Otherwise sr holds its value.
- Edge detector: `clk_q` and `strobe_q` register joy_clock and joy_strobe. latch_pulse = strobe_q & ~joy_strobe, registered.
- After 8 shifts, all bits read C_fill indefinitely until the next strobe.

## Timing
- Reset values:
  - All sr = 0, so joy_data = 0.
  - latch_pulse = 0, autofire_phase = 0 (1 when C_autofire_hz=0).
  - Divider counter = 0, synchroniser flops = 0, clk_q = 0, strobe_q = 0.
- Reset mid-read clears sr. The first cycle after R_reset deasserts behaves as idle.
- Latency:
  - btn_in change → eff: C_sync_stages cycles.
  - eff → joy_data while strobed: +1 cycle.
- joy_clock falling edge (observed at cycle n) → new joy_data at cycle n+1.
- joy_strobe falling edge at cycle n → latch_pulse high during cycle n+1 only.
- Autofire: phase toggles every HALF cycles, so the full period is 2*HALF cycles. Default HALF = 1071428.
- A button released while strobe=0 does not affect the shifting report; only the next strobe samples it.

## Test plan
- Reset with C_ports=2, btn_in=16'h0000 → joy_data=2'b00, latch_pulse=0, autofire_phase=0.
- btn_in port0=8'b1000_1001 (A, start, right) held 3 cycles. Pulse strobe, then apply 10 joy_clock falls → joy_data[0] reads 1,0,0,1,0,0,0,1,1,1. joy_data[1] reads 0×8 followed by 1,1. latch_pulse is a single cycle.
- Hold strobe high; toggle btn_in[0] 0→1 → joy_data[0] rises exactly C_sync_stages+1 cycles later.
- Assert a joy_clock falling edge in the same cycle as strobe=1 with eff=8'h02 → sr reloads and joy_data[0]=0, with no shift.
- C_clk_hz=1000, C_autofire_hz=50 (HALF=10), A held, af bit0=1 → autofire_phase toggles every 10 cycles. A strobe during phase=0 reads A=0; a strobe during phase=1 reads A=1. B is unaffected.
- Assert R_reset after 3 of 8 shifts → joy_data=0 the next cycle. The next strobe reloads a fresh report.
